// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single synchronous ROM: port A (fetch) and Wishbone port B.
// Define ROM_ARB_RR_EN for round-robin conflict resolution; default build gives A fixed priority.
module rom_arbiter #(
  parameter int addr_width = 12,
  parameter int data_width = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic [addr_width-1:0] a_addr,
  output logic                  a_ack,
  output logic [data_width-1:0] a_data,
  input  logic                  b_cyc,
  input  logic                  b_stb,
  input  logic [addr_width-1:0] b_adr,
  output logic                  b_ack,
  output logic [data_width-1:0] b_dat_o,
  output logic [addr_width-1:0] rom_address,
  output logic                  rom_cen,
  input  logic [data_width-1:0] rom_q
);

  logic a_busy;
  logic b_busy;
  logic a_elig;
  logic b_elig;
  logic grant_a;
  logic grant_b;

  // A port stays ineligible in its ack cycle because its read is still in flight.
  assign a_elig = a_req & ~a_busy;
  assign b_elig = b_cyc & b_stb & ~b_busy;

`ifdef ROM_ARB_RR_EN
  logic last_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_b <= 1'b1;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_elig && b_elig) begin
        grant_a = last_b;
        grant_b = ~last_b;
      end else begin
        grant_a = a_elig;
        grant_b = b_elig;
      end
    end
  end
`else
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      grant_a = a_elig;
      grant_b = b_elig & ~a_elig;
    end
  end
`endif

  // Each in-flight flag lives for exactly the cycle after its grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_busy <= 1'b0;
      b_busy <= 1'b0;
    end else begin
      a_busy <= grant_a;
      b_busy <= grant_b;
    end
  end

  assign rom_cen     = grant_a | grant_b;
  assign rom_address = grant_b ? b_adr : a_addr;

  // A B read whose cycle was abandoned before the data returned is silently dropped.
  assign a_ack   = a_busy & ~reset;
  assign b_ack   = b_busy & b_cyc & b_stb & ~reset;
  assign a_data  = rom_q;
  assign b_dat_o = rom_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios followed by protocol-legal random traffic,
// checked against a cycle-stamped grant model and a behavioural synchronous ROM.
module tb_rom_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_ack;
  logic [DW-1:0] a_data;
  logic          b_cyc;
  logic          b_stb;
  logic [AW-1:0] b_adr;
  logic          b_ack;
  logic [DW-1:0] b_dat_o;
  logic [AW-1:0] rom_address;
  logic          rom_cen;
  logic [DW-1:0] rom_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: the cycle each port was last granted and the address it read.
  int            cyc    = 0;
  int            a_gcyc = -10;
  int            b_gcyc = -10;
  logic [AW-1:0] a_gaddr = '0;
  logic [AW-1:0] b_gaddr = '0;
  bit            last_b = 1'b1;
  bit            saw_a_ack;
  bit            saw_b_ack;

  rom_arbiter #(.addr_width(AW), .data_width(DW)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
    .b_cyc(b_cyc), .b_stb(b_stb), .b_adr(b_adr), .b_ack(b_ack), .b_dat_o(b_dat_o),
    .rom_address(rom_address), .rom_cen(rom_cen), .rom_q(rom_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rom_cen) rom_q <= mem[rom_address];
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit            a_fl, b_fl, a_el, b_el, ga, gb, e_cen, e_aack, e_back;
    logic [AW-1:0] e_addr;
    @(negedge clock);
    a_fl = (a_gcyc == cyc - 1);
    b_fl = (b_gcyc == cyc - 1);
    ga = 1'b0;
    gb = 1'b0;
    e_addr = a_addr;
    if (reset) begin
      e_cen  = 1'b0;
      e_aack = 1'b0;
      e_back = 1'b0;
    end else begin
      a_el = a_req && !a_fl;
      b_el = b_cyc && b_stb && !b_fl;
      ga = a_el;
      gb = b_el;
      if (a_el && b_el) begin
`ifdef ROM_ARB_RR_EN
        ga = last_b;
        gb = !last_b;
`else
        gb = 1'b0;
`endif
      end
      e_cen  = ga || gb;
      e_addr = gb ? b_adr : a_addr;
      e_aack = a_fl;
      e_back = b_fl && b_cyc && b_stb;
    end
    cmp("rom_cen", 32'(rom_cen), 32'(e_cen));
    cmp("a_ack", 32'(a_ack), 32'(e_aack));
    cmp("b_ack", 32'(b_ack), 32'(e_back));
    if (!reset) cmp("rom_address", 32'(rom_address), 32'(e_addr));
    if (e_aack) cmp("a_data", 32'(a_data), 32'(mem[a_gaddr]));
    if (e_back) cmp("b_dat_o", 32'(b_dat_o), 32'(mem[b_gaddr]));
    saw_a_ack = e_aack;
    saw_b_ack = e_back;
    @(posedge clock);
    if (reset) begin
      a_gcyc = -10;
      b_gcyc = -10;
      last_b = 1'b1;
    end else begin
      if (ga) begin
        a_gcyc  = cyc;
        a_gaddr = a_addr;
        last_b  = 1'b0;
      end
      if (gb) begin
        b_gcyc  = cyc;
        b_gaddr = b_adr;
        last_b  = 1'b1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic applyStimulus(input bit rst, input bit ar, input logic [AW-1:0] aa,
                               input bit bc, input bit bs, input logic [AW-1:0] ba);
    reset  = rst;
    a_req  = ar;
    a_addr = aa;
    b_cyc  = bc;
    b_stb  = bs;
    b_adr  = ba;
    checkOutput();
  endtask

  initial begin
    bit            a_pend;
    bit            b_pend;
    logic [31:0]   r;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;

    for (int i = 0; i < (1 << AW); i++) begin
      r = $urandom;
      mem[i] = r[DW-1:0];
    end
    rom_q = '0;

    $display("[TB] reset with requests pending");
    applyStimulus(1, 1, 12'h010, 1, 1, 12'h030);
    applyStimulus(1, 1, 12'h010, 1, 1, 12'h030);

    $display("[TB] port A alone at 0x010");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 12'h010, 0, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);

    $display("[TB] A and B continuous at 0x020/0x030");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 12'h020, 1, 1, 12'h030);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);

    $display("[TB] first conflict after reset");
    applyStimulus(1, 0, 12'h000, 0, 0, 12'h000);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 12'h021, 1, 1, 12'h031);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);

    $display("[TB] B abort then retry");
    applyStimulus(0, 0, 12'h000, 1, 1, 12'h040);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h040);
    applyStimulus(0, 0, 12'h000, 1, 1, 12'h041);
    applyStimulus(0, 0, 12'h000, 1, 1, 12'h041);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);

    $display("[TB] reset across an A read");
    applyStimulus(0, 1, 12'h055, 0, 0, 12'h000);
    applyStimulus(1, 1, 12'h055, 0, 0, 12'h000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 12'h055, 0, 0, 12'h000);
    applyStimulus(0, 0, 12'h000, 0, 0, 12'h000);

    $display("[TB] random traffic");
    a_pend = 1'b0;
    b_pend = 1'b0;
    ra = '0;
    rb = '0;
    for (int i = 0; i < 600; i++) begin
      if (!a_pend && ($urandom_range(0, 1) == 1)) begin
        r = $urandom;
        ra = r[AW-1:0];
        a_pend = 1'b1;
      end
      if (b_pend && ($urandom_range(0, 7) == 0)) begin
        b_pend = 1'b0;
      end else if (!b_pend && ($urandom_range(0, 1) == 1)) begin
        r = $urandom;
        rb = r[AW-1:0];
        b_pend = 1'b1;
      end
      applyStimulus(($urandom_range(0, 63) == 0), a_pend, ra, b_pend, b_pend, rb);
      if (saw_a_ack) a_pend = 1'b0;
      if (saw_b_ack) b_pend = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
